// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter/sequencer driving a parallel register bank's next-state array.
// Latency: grant registered one cycle after the request is sampled; d_o is combinational in the beat.
// Backpressure: requesters hold req/addr/data until granted; locked bursts are capped at BURST_MAX beats.
module regbank_wr_arbiter #(
   parameter  int N         = 4,
   parameter  int M         = 16,
   parameter  int R         = 4,
   parameter  int BURST_MAX = 4,
   localparam int AW        = (M > 1) ? $clog2(M) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [R-1:0]  req_i,
   input  logic [R-1:0]  lock_i,
   input  logic [AW-1:0] addr_i [0:R-1],
   input  logic [N-1:0]  data_i [0:R-1],
   input  logic [N-1:0]  q_i    [0:M-1],
   output logic [N-1:0]  d_o    [0:M-1],
   output logic [R-1:0]  gnt_o,
   output logic          busy_o,
   output logic          wr_err_o
);

   localparam int RW  = $clog2(R);
   localparam int CW  = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam int AWP = AW + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(BURST_MAX - 1);
   localparam logic [AWP-1:0] ADDR_LIM = AWP'(M);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GNT  = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [RW-1:0] owner_q, owner_d;
   logic [RW-1:0] ptr_q,   ptr_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [R-1:0]  gnt_q,   gnt_d;
   logic          err_q,   err_d;

   logic [AW-1:0] cur_addr;
   logic [N-1:0]  cur_data;
   logic          beat;
   logic          in_range;
   logic [RW-1:0] rel_ptr;
   logic [RW-1:0] srch_start;
   logic [RW-1:0] cand;
   logic          win_vld;
   logic [RW-1:0] win_idx;

   // Current owner's request view: is this cycle a write beat, and does its address hit the bank
   always_comb begin
      cur_addr = addr_i[owner_q];
      cur_data = data_i[owner_q];
      beat     = (state_q == ST_GNT) && req_i[owner_q];
      in_range = {1'b0, cur_addr} < ADDR_LIM;
      rel_ptr  = (owner_q == RW'(R - 1)) ? '0 : owner_q + RW'(1);
   end

   // Round-robin winner search; while granted it starts after the owner and skips the owner
   always_comb begin
      srch_start = (state_q == ST_GNT) ? rel_ptr : ptr_q;
      cand       = '0;
      win_vld    = 1'b0;
      win_idx    = '0;
      for (int i = 0; i < R; i++) begin
         cand = RW'((int'(srch_start) + i) % R);
         if (!win_vld && req_i[cand] && !((state_q == ST_GNT) && (cand == owner_q))) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // State register: all arbiter state clears asynchronously
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state: grant from idle, extend a locked burst, or release and hand over
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               state_d = ST_GNT;
               owner_d = win_idx;
               cnt_d   = '0;
            end
         end
         ST_GNT: begin
            if (req_i[owner_q] && lock_i[owner_q] && (cnt_q < CNT_LAST)) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               // Released owner is skipped at this edge only, so it may win again from idle
               ptr_d = rel_ptr;
               cnt_d = '0;
               if (win_vld) begin
                  owner_d = win_idx;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs: next grant vector, out-of-range flag, and the bank next-state array
   always_comb begin
      gnt_d = '0;
      if (state_d == ST_GNT) begin
         gnt_d[owner_d] = 1'b1;
      end
      err_d = beat && !in_range;
      for (int m = 0; m < M; m++) begin
         d_o[m] = q_i[m];
         if (beat && in_range && (cur_addr == AW'(m))) begin
            d_o[m] = cur_data;
         end
      end
   end

   assign gnt_o    = gnt_q;
   assign busy_o   = (state_q == ST_GNT);
   assign wr_err_o = err_q;

endmodule

// File: doc/regbank_wr_arbiter.md
# regbank_wr_arbiter

Round-robin write arbiter and sequencer for the parallel register bank (N-bit × M-word array that reloads every word on every clock). Up to R requesters compete for the bank's single write path. The block grants one requester at a time, with optional locked bursts. Each cycle it drives the bank's next-state array: the bank's current contents with at most one word replaced.

## Interface
- N, 4, data width of one bank word
- M, 16, number of bank words
- R, 4, number of requesters (≥2)
- BURST_MAX, 4, maximum beats per locked grant (≥1)
- AW, $clog2(M), address width (derived, not overridable)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- req_i  in  R  per-requester write request
- lock_i  in  R  per-requester burst-hold request, sampled only for the current owner
- addr_i  in  R×AW  per-requester word address
- data_i  in  R×N  per-requester write data
- q_i  in  N×[0:M-1]  current bank contents (bank outputs)
- d_o  out  N×[0:M-1]  bank next-state array (bank inputs)
- gnt_o  out  R  registered one-hot grant
- busy_o  out  1  grant active (state GNT)
- wr_err_o  out  1  registered pulse: granted beat had addr ≥ M

## Operation
- States: IDLE (gnt_o=0) and GNT (owner k, gnt_o=1<<k). Registers: state, owner, ptr (round-robin start, 0..R-1), beat_cnt (0..BURST_MAX-1).
- Reset values: state=IDLE, gnt_o=0, ptr=0, beat_cnt=0, busy_o=0, wr_err_o=0. d_o=q_i (no write).
- Winner search: first asserted eligible req_i[j], scanning j=ptr, ptr+1, …, wrapping mod R.
- IDLE:
  - If any req_i is high, go to GNT with owner=winner and beat_cnt=0.
  - Otherwise stay in IDLE.
- GNT, owner k. A write beat is any cycle with gnt_o[k]=1 and req_i[k]=1.
  - Continue: req_i[k]=1, lock_i[k]=1 and beat_cnt<BURST_MAX-1. Stay on k, beat_cnt+1.
  - Otherwise release: ptr=(k+1) mod R.
    - Search for a winner among requesters j≠k. The released owner is excluded at this edge only.
    - If a winner is found, go to GNT with the new owner and beat_cnt=0.
    - If none is found, go to IDLE.
- d_o, combinational:
  - During a write beat with addr_i[k]<M: d_o[addr_i[k]]=data_i[k]. Every other word equals q_i.
  - In all other cycles: d_o=q_i.
- Beat with addr_i[k]≥M (non-power-of-2 M): no word changes. wr_err_o=1 in the next cycle. The beat still counts toward beat_cnt.
- Requester protocol:
  - Hold req/addr/data stable until gnt_o[k] is seen.
  - In the cycle after each beat, either present the next beat or deassert req.
  - req_i[k] low while granted is not a beat. It forces release at the next edge.
- Reset asserted mid-grant: gnt_o drops immediately (async). A beat in that cycle is lost (bank ignores the clock in reset). No state survives reset.

## Timing
- Request to first grant: req_i sampled at edge E, gnt_o high after E. Minimum 1 cycle from IDLE.
- Write landing: a beat in cycle c appears on q_i after the next rising edge (bank register).
- Unlocked grant lasts exactly 1 cycle. A locked grant lasts at most BURST_MAX consecutive cycles, then is forcibly released.
- Handover between different requesters has no idle cycle.
- A sole requester doing repeated single beats is granted every other cycle (release exclusion → IDLE → re-grant).
- Simultaneous requests: ordering is by ptr only. The lock_i of non-owners is ignored.
- wr_err_o is a 1-cycle pulse, 1 cycle after the offending beat.

## Test plan
- Reset, then req_i=4'b0001, addr=3, data=4'hA: gnt_o=0001 one cycle after the sampling edge. d_o[3]=A during the grant. q_i[3]=A next cycle. Then busy_o=0 and ptr=1.
- req_i=4'b1111 held, lock_i=0, distinct data: grants go 0,1,2,3,0 on consecutive cycles with no gap. Exactly one word changes per cycle.
- Requester 2 with lock_i=1 and 6 beats (addr 0..5), requester 0 also requesting: requester 2 gets 4 beats. Requester 0 is granted the next cycle. Requester 2 resumes after that with addr 4.
- Sole requester 1 with req held 4 cycles, lock_i=0: gnt_o[1] pattern is 1,0,1,0. Two writes occur, never on adjacent cycles.
- M=12, addr=13, data=5: no q_i word changes. wr_err_o=1 for exactly one cycle after the beat.
- rst_i low mid-burst (beat 2 of 4): gnt_o=0 immediately. d_o=q_i. After release, ptr=0 and arbitration restarts from requester 0.
